// File: rtl/conv_pkg.sv
// Shared definitions for the Conv IFMap stream: word tag layout and the
// tag encodings the Conv IF buffer expects.
package conv_pkg;

    // Bit positions inside the 2-bit tag, which sits above the data bits
    localparam int TAG_SOR = 1;
    localparam int TAG_EOR = 0;

    typedef logic [1:0] ifmap_tag_t;

    localparam ifmap_tag_t TAG_MID    = 2'b00;
    localparam ifmap_tag_t TAG_FIRST  = 2'b10;
    localparam ifmap_tag_t TAG_LAST   = 2'b01;
    localparam ifmap_tag_t TAG_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_RUN,
        TX_FIN
    } tx_state_t;

    function automatic ifmap_tag_t make_tag(input logic sor, input logic eor);
        ifmap_tag_t t;
        t          = TAG_MID;
        t[TAG_SOR] = sor;
        t[TAG_EOR] = eor;
        return t;
    endfunction

endpackage

// File: rtl/ifmap_tx_skid.sv
// Two-entry valid/ready FIFO holding tagged IFMap words; head is presented
// directly so it stays stable while the consumer stalls.
module ifmap_tx_skid #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop;

    assign out_valid = (occ != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    // The producer guarantees it never pushes into a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (in_valid) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, in_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ifmap_tx.sv
// Streams num_rows x row_len words from a sync-read memory into the Conv IF
// buffer, tagging start/end of row, with credit-based read issue.
module ifmap_tx
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [LEN_WIDTH-1:0]  num_rows,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  IF_buff_ready,
    output logic                  IF_buff_wen,
    output logic [DATA_WIDTH+1:0] IFMap
);

    tx_state_t             state, state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len_q, rows_q, col, row;
    logic                  issued_all, rd_pend;
    logic                  pop, last_col, last_row, last_pop, zero_len;
    ifmap_tag_t            tag_pend;
    logic [1:0]            occ;
    logic [2:0]            load;

    assign pop      = IF_buff_wen && IF_buff_ready;
    // Words the FIFO must still absorb after this edge; a same-cycle pop frees
    // a slot, which is what sustains one word per cycle.
    assign load     = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
    assign last_col = (col == len_q - LEN_WIDTH'(1));
    assign last_row = (row == rows_q - LEN_WIDTH'(1));
    assign last_pop = pop && issued_all && !rd_pend && (occ == 2'd1);
    assign zero_len = (row_len == '0) || (num_rows == '0);

    assign busy     = (state == TX_RUN);
    assign done     = (state == TX_FIN);
    assign mem_ren  = busy && !issued_all && (load < 3'd2);
    assign mem_addr = addr;

    always_comb begin
        state_nx = state;
        case (state)
            TX_IDLE: if (start) state_nx = zero_len ? TX_FIN : TX_RUN;
            TX_RUN:  if (last_pop) state_nx = TX_FIN;
            TX_FIN:  state_nx = TX_IDLE;
            default: state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TX_IDLE;
            addr       <= '0;
            len_q      <= '0;
            rows_q     <= '0;
            col        <= '0;
            row        <= '0;
            issued_all <= 1'b0;
            rd_pend    <= 1'b0;
            tag_pend   <= TAG_MID;
        end else begin
            state   <= state_nx;
            rd_pend <= mem_ren;
            if (mem_ren) tag_pend <= make_tag(col == '0, last_col);
            if (state == TX_IDLE && start) begin
                addr       <= base_addr;
                len_q      <= row_len;
                rows_q     <= num_rows;
                col        <= '0;
                row        <= '0;
                issued_all <= 1'b0;
            end else if (mem_ren) begin
                addr <= addr + ADDR_WIDTH'(1);
                if (last_col) begin
                    col        <= '0;
                    row        <= row + LEN_WIDTH'(1);
                    issued_all <= last_row;
                end else begin
                    col <= col + LEN_WIDTH'(1);
                end
            end
        end
    end

    ifmap_tx_skid #(
        .WIDTH(DATA_WIDTH + 2)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_pend),
        .in_data  ({tag_pend, mem_rdata}),
        .out_valid(IF_buff_wen),
        .out_data (IFMap),
        .out_ready(IF_buff_ready),
        .occ      (occ)
    );

endmodule

// File: tb/tb_ifmap_tx.sv
// Directed bench for ifmap_tx: memory model, handshake monitor and checks.
module tb_ifmap_tx;
    import conv_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] row_len = '0;
    logic [LW-1:0] num_rows = '0;
    logic          busy, done, mem_ren, IF_buff_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          IF_buff_ready = 1'b1;
    logic [DW+1:0] IFMap;

    int            checks = 0;
    int            fails = 0;
    logic [DW-1:0] mem [256];
    logic [DW+1:0] got_q [$];
    logic [AW-1:0] addr_q [$];
    int            issued = 0;
    int            delivered = 0;
    logic          prev_stall = 1'b0;
    logic [DW+1:0] prev_word = '0;

    always #5 clk = ~clk;

    ifmap_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .row_len(row_len), .num_rows(num_rows), .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .IF_buff_ready(IF_buff_ready), .IF_buff_wen(IF_buff_wen), .IFMap(IFMap)
    );

    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake monitor: records reads and delivered words, checks hold/outstanding
    initial forever begin
        @(posedge clk);
        if (rst) begin
            issued = 0; delivered = 0; prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_wen", IF_buff_wen, 1);
                chk("stall_hold", IFMap, prev_word);
            end
            if (mem_ren) begin addr_q.push_back(mem_addr); issued++; end
            if (IF_buff_wen && IF_buff_ready) begin got_q.push_back(IFMap); delivered++; end
            if (mem_ren) chk("outstanding", (issued - delivered) <= 2, 1);
            prev_stall = IF_buff_wen && !IF_buff_ready;
            prev_word  = IFMap;
        end
    end

    // mode 0: ready high, 1: stall on word 3 then random ready, 2: start re-pulse
    task automatic run(input logic [7:0] b, input logic [7:0] l, input logic [7:0] r,
                       input int mode, output int done_at, output int first_wen);
        tick();
        got_q.delete(); addr_q.delete();
        base_addr = b; row_len = l; num_rows = r; start = 1'b1; IF_buff_ready = 1'b1;
        done_at = -1; first_wen = -1;
        for (int n = 1; n <= 400; n++) begin
            tick();
            start = 1'b0;
            if (mode == 1) begin
                if (n == 5) chk("bp_stall_on_word3", got_q.size(), 2);
                IF_buff_ready = (n < 5) ? 1'b1 : (n <= 9) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            if (mode == 2 && n == 4) begin
                start = 1'b1; base_addr = 8'd100; row_len = 8'd3; num_rows = 8'd1;
            end
            if (n == 1) chk("busy_cycle1", busy, (l != 0 && r != 0));
            if (first_wen < 0 && IF_buff_wen) first_wen = n;
            if (done) begin done_at = n; break; end
        end
        IF_buff_ready = 1'b1;
        if (done_at < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic check_words(input string tag, input logic [7:0] b, input logic [7:0] l,
                               input logic [7:0] r);
        int nw;
        nw = int'(l) * int'(r);
        chk({tag, "_count"}, got_q.size(), nw);
        chk({tag, "_reads"}, addr_q.size(), nw);
        for (int i = 0; i < nw && i < got_q.size() && i < addr_q.size(); i++) begin
            logic [7:0]    a;
            logic [DW+1:0] exp;
            a   = b + 8'(i);
            exp = {(i % int'(l)) == 0, (i % int'(l)) == int'(l) - 1, mem[a]};
            chk({tag, "_word"}, got_q[i], exp);
            chk({tag, "_addr"}, addr_q[i], a);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_ren"}, mem_ren, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_wen"}, IF_buff_wen, 0);
        chk({tag, "_ifmap"}, IFMap, 0);
    endtask

    initial begin
        int d, f;
        int vals [12];
        int wa [4];
        logic [1:0] t;
        vals = '{14, 39, 164, 171, -6, -80, 122, 9, 155, -51, -26, 147};
        wa   = '{254, 255, 0, 1};
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 7 + 3);
        for (int i = 0; i < 12; i++) mem[i] = 16'(vals[i]);

        rst = 1'b1;
        tick(); tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Nominal 2x6 stream
        run(8'd0, 8'd6, 8'd2, 0, d, f);
        chk("nom_done_cycle", d, 15);
        chk("nom_first_wen", f, 3);
        check_words("nom", 8'd0, 8'd6, 8'd2);
        if (got_q.size() == 12) begin
            t = got_q[0][17:16];  chk("nom_tag_first", t, TAG_FIRST);
            t = got_q[5][17:16];  chk("nom_tag_last", t, TAG_LAST);
            t = got_q[6][17:16];  chk("nom_tag_row2", t, TAG_FIRST);
            t = got_q[2][17:16];  chk("nom_tag_mid", t, TAG_MID);
            chk("nom_data_neg", got_q[4][15:0], 16'hFFFA);
        end

        // Backpressure
        run(8'd0, 8'd6, 8'd2, 1, d, f);
        chk("bp_done_seen", d > 0, 1);
        check_words("bp", 8'd0, 8'd6, 8'd2);

        // Single-column rows
        run(8'd20, 8'd1, 8'd3, 0, d, f);
        chk("col1_done_cycle", d, 6);
        check_words("col1", 8'd20, 8'd1, 8'd3);
        for (int i = 0; i < got_q.size(); i++) begin
            t = got_q[i][17:16];
            chk("col1_tag", t, TAG_SINGLE);
        end

        // Zero length
        run(8'd0, 8'd6, 8'd0, 0, d, f);
        chk("zero_done_cycle", d, 1);
        chk("zero_reads", addr_q.size(), 0);
        chk("zero_words", got_q.size(), 0);

        // Address wrap
        run(8'd254, 8'd4, 8'd1, 0, d, f);
        chk("wrap_done_cycle", d, 7);
        chk("wrap_nreads", addr_q.size(), 4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++) chk("wrap_addr", addr_q[i], wa[i]);
        check_words("wrap", 8'd254, 8'd4, 8'd1);

        // Start re-pulsed mid-transfer is ignored
        run(8'd0, 8'd6, 8'd2, 2, d, f);
        chk("abuse_done_cycle", d, 15);
        check_words("abuse", 8'd0, 8'd6, 8'd2);

        // Reset during word 4
        tick(); tick();
        base_addr = 8'd0; row_len = 8'd6; num_rows = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("rst_word4", IFMap, {2'b00, mem[3]});
        rst = 1'b1;
        tick();
        check_idle_outputs("midrst");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_done", done, 0);
            chk("midrst_idle", busy, 0);
        end
        run(8'd0, 8'd6, 8'd2, 0, d, f);
        chk("post_rst_done_cycle", d, 15);
        check_words("post_rst", 8'd0, 8'd6, 8'd2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/ifmap_tx.md
# ifmap_tx

Transmitter side of the Conv IFMap input stream. Reads IFMap rows from a synchronous read-port memory and emits tagged words (`{start_of_row, end_of_row, data}`) into the Conv IF buffer. Stops when that buffer deasserts `IF_buff_ready`. One transfer of `num_rows × row_len` words is run per `start` pulse. Sits between the activation SRAM and the `Conv` IFMap write port, replacing bench-driven stimulus.

## Interface
- `DATA_WIDTH`, 16, IFMap element width (matches Conv `IFMap_WIDTH`).
- `ADDR_WIDTH`, 8, memory address width.
- `LEN_WIDTH`, 8, width of `row_len` / `num_rows`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a transfer. Ignored while `busy`.
- `base_addr` in `ADDR_WIDTH`: address of the first word. Sampled with `start`.
- `row_len` in `LEN_WIDTH`: words per row. Sampled with `start`.
- `num_rows` in `LEN_WIDTH`: rows per transfer. Sampled with `start`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `mem_ren` out 1: memory read enable.
- `mem_addr` out `ADDR_WIDTH`: memory read address.
- `mem_rdata` in `DATA_WIDTH`: read data, valid the cycle after `mem_ren`.
- `IF_buff_ready` in 1: Conv IF buffer can accept a word.
- `IF_buff_wen` out 1: word valid on `IFMap`.
- `IFMap` out `DATA_WIDTH+2`: bit `DATA_WIDTH+1` = start of row, bit `DATA_WIDTH` = end of row, low bits = data.

## Operation
- Reset value of every output is 0: `busy`, `done`, `mem_ren`, `mem_addr`, `IF_buff_wen`, `IFMap`.
- States:
  - IDLE: `start` → RUN. If `row_len==0` or `num_rows==0`, go to FIN instead and emit no words.
  - RUN: issue reads and forward words. After the last word handshakes → FIN.
  - FIN: `done=1` for one cycle → IDLE.
- Address generation:
  - A running address counter starts at `base_addr` and increments by 1 per read.
  - It wraps modulo 2^`ADDR_WIDTH`. Rows are contiguous.
- Row and column counters advance per read issued, not per word delivered.
- Tags are computed at read issue and piped alongside the data:
  - SOR = (col==0).
  - EOR = (col==row_len−1).
  - When `row_len==1`, both bits are set (tag `2'b11`).
- A transfer happens on every cycle where `IF_buff_wen && IF_buff_ready`.
- While `IF_buff_wen && !IF_buff_ready`, `IFMap` and `IF_buff_wen` hold stable.
- Words are buffered in a 2-entry skid FIFO. A read is issued only when (FIFO occupancy + reads in flight) < 2, so no word is ever dropped.
- `start` while `busy` is ignored and parameters are not resampled.
- `rst` mid-transfer:
  - Counters, FIFO and FSM are cleared at that edge.
  - `IF_buff_wen` and `mem_ren` are 0 the following cycle.
  - No `done` is generated.

## Timing
- `start` sampled at edge E0.
- Cycle after E0: `busy=1`, `mem_ren=1`, `mem_addr=base_addr`.
- `mem_rdata` valid the next cycle. It is registered into the FIFO and presented on `IFMap` one cycle later.
- First `IF_buff_wen` occurs 3 cycles after the `start` edge.
- With `IF_buff_ready` held high, throughput is 1 word per cycle after the first word.
- After `IF_buff_ready` rises again following a stall, the next word transfers in that same cycle. No bubble beyond one cycle on resume.
- `done` is high the cycle after the final handshake. `busy` falls in that same cycle.
- Total cycles from `start` to `done` with no backpressure: N+3, where N = `row_len × num_rows`.
- Zero-length transfer: `busy` stays 0 and `done` pulses the cycle after `start`.

## Structure
- Shared package `conv_pkg` holds:
  - `TAG_SOR`/`TAG_EOR` bit-position localparams.
  - `ifmap_tag_t` (2-bit) typedef.
  - The encodings used by `Conv`'s IF buffer.
- One sub-module, `ifmap_tx_skid`: 2-entry valid/ready FIFO of `DATA_WIDTH+2` bits with occupancy output.
- The FSM, counters and address generation live in `ifmap_tx`.

## Test plan
- Nominal stream:
  - Setup: `row_len=6`, `num_rows=2`, memory at `base_addr=0` holds 14,39,164,171,−6,−80,122,9,155,−51,−26,147; `IF_buff_ready` held at 1.
  - Required: 12 consecutive words.
  - Tags are 10,00,00,00,00,01 for each row.
  - Data matches memory order.
  - `done` lands exactly 15 cycles after the `start` edge.
- Backpressure:
  - Stimulus: same transfer, `IF_buff_ready` toggled pseudo-randomly, plus a 5-cycle stall during the 3rd word.
  - Required: `IFMap` stable during stalls; no loss or duplication; `mem_ren` never leaves >2 words outstanding.
- Single-column rows:
  - Stimulus: `row_len=1`, `num_rows=3`.
  - Required: 3 words, each tagged `2'b11`.
- Zero length and wrap:
  - Stimulus: `num_rows=0`.
  - Required: no `mem_ren`, no `IF_buff_wen`, and `done` the cycle after `start`.
  - Stimulus: `base_addr=254`, `ADDR_WIDTH=8`, 4 words.
  - Required: addresses 254, 255, 0, 1.
- Reset and start abuse:
  - Stimulus: `start` re-pulsed mid-transfer.
  - Required: it is ignored and the original transfer completes unchanged.
  - Stimulus: `rst` asserted during word 4.
  - Required: all outputs are 0 the next cycle; no `done`; a fresh `start` then runs a clean transfer.
